pulse_detector: RTL and testbench

PULSE_DETECTOR -- requirements
Module: pulse_detector

---
 rtl/pulse_detector.sv | 85 ++++++++
 tb/tb_pulse_detector.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_detector.sv
// Synchronizes an asynchronous pulse input and emits a single registered pulse
// a programmable number of clock cycles after each detected rising edge.
module pulse_detector #(
  parameter int unsigned DELAY_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sig_in,
  input  logic [DELAY_W-1:0] delay,
  output logic               sig_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StFire = 2'd2;

  logic               s1, s2, s3;
  logic               rise;
  logic [1:0]         state_q, state_d;
  logic [DELAY_W-1:0] count_q, count_d;
  logic               sig_out_q;

  // s1/s2 form the synchronizer; s3 only exists to detect the s2 edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          if (delay == '0) begin
            state_d = StFire;
          end else begin
            count_d = delay;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end
        // A zero count here is unreachable; fire anyway rather than stall.
        if (count_q <= DELAY_W'(1)) begin
          state_d = StFire;
        end
      end
      StFire: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      sig_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      // Registered alongside the state so the output is high exactly in StFire.
      sig_out_q <= (state_d == StFire);
    end
  end

  assign sig_out = sig_out_q;

endmodule

// File: tb/tb_pulse_detector.sv
// Directed and randomized checks of pulse_detector against a sample-history
// model of when each output pulse is due.
module tb_pulse_detector;

  localparam int unsigned DELAY_W = 8;

  logic               clk;
  logic               reset;
  logic               sig_in;
  logic [DELAY_W-1:0] delay;
  logic               sig_out;

  int checks;
  int failures;

  // Reference model: every sampled sig_in value since reset release, indexed by edge.
  bit samp[$];
  int edge_idx;
  int fire_at;
  int next_free;
  bit in_reset;
  int model_pulses;
  int dut_pulses;

  pulse_detector #(.DELAY_W(DELAY_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .delay  (delay),
    .sig_out(sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit samp_at(int i);
    if (i < 0) return 1'b0;
    return samp[i];
  endfunction

  task automatic model_clear();
    samp.delete();
    edge_idx  = 0;
    fire_at   = -1;
    next_free = 0;
  endtask

  task automatic check(input string tag, input bit exp);
    checks++;
    assert (sig_out === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, sig_out, exp);
    end
  endtask

  // One clock edge: update the model, then compare the output 1 ns later.
  task automatic step(input string tag, input int n);
    bit exp;
    bit took;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      exp = 1'b0;
      if (!in_reset) begin
        samp.push_back(sig_in);
        // Seen as a rise two edges after sampling 1, following a sampled 0.
        took = samp_at(edge_idx - 2) && !samp_at(edge_idx - 3) && (edge_idx >= next_free);
        if (took) begin
          fire_at   = edge_idx + int'(delay);
          next_free = fire_at + 2;
        end
        exp = (edge_idx == fire_at);
        if (exp) model_pulses++;
        edge_idx++;
      end
      #1;
      if (sig_out === 1'b1) dut_pulses++;
      check(tag, exp);
    end
  endtask

  // Called 1 ns after an edge; asserts reset mid-cycle and releases mid-cycle.
  task automatic pulse_reset(input string tag, input int cycles);
    #2 reset = 1'b0;
    in_reset = 1'b1;
    #1 check({tag, "_async"}, 1'b0);
    model_clear();
    step({tag, "_held"}, cycles);
    #3 reset = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    model_pulses = 0;
    dut_pulses   = 0;
    in_reset     = 1'b1;
    reset        = 1'b0;
    sig_in       = 1'b0;
    delay        = '0;
    model_clear();

    #1 check("reset_state", 1'b0);
    step("reset_held", 2);
    #3 reset = 1'b1;
    in_reset = 1'b0;
    step("idle", 4);

    // delay=0, level held high: exactly one pulse
    delay  = 8'd0;
    sig_in = 1'b1;
    step("d0_held", 20);
    sig_in = 1'b0;
    step("d0_low", 5);

    // delay=5, 3-cycle pulse
    delay  = 8'd5;
    sig_in = 1'b1;
    step("d5_pulse", 3);
    sig_in = 1'b0;
    step("d5_wait", 15);

    // delay=10, second pulse arrives during WAIT and is ignored
    delay  = 8'd10;
    sig_in = 1'b1;
    step("d10_first", 2);
    sig_in = 1'b0;
    step("d10_gap", 2);
    sig_in = 1'b1;
    step("d10_second", 2);
    sig_in = 1'b0;
    step("d10_wait", 20);

    // delay=3, reset during WAIT aborts; still-high input gives a fresh detection
    delay  = 8'd3;
    sig_in = 1'b1;
    step("d3_pre", 4);
    pulse_reset("d3_rst", 2);
    step("d3_post", 12);
    sig_in = 1'b0;
    step("d3_low", 3);

    // delay=255, changed to 1 mid-WAIT without effect
    delay  = 8'd255;
    sig_in = 1'b1;
    step("d255_rise", 3);
    sig_in = 1'b0;
    step("d255_wait", 10);
    delay = 8'd1;
    step("d255_chg", 250);
    step("d255_tail", 8);

    // Toggle every cycle with delay=0
    delay        = 8'd0;
    model_pulses = 0;
    dut_pulses   = 0;
    for (int i = 0; i < 40; i++) begin
      sig_in = ~sig_in;
      step("toggle", 1);
    end
    sig_in = 1'b0;
    step("toggle_tail", 4);
    checks++;
    assert (dut_pulses == model_pulses) else begin
      failures++;
      $error("FAIL toggle_count observed=%0d expected=%0d", dut_pulses, model_pulses);
    end

    // Randomized runs of sig_in levels, varied delay, occasional reset
    for (int i = 0; i < 150; i++) begin
      sig_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) delay = DELAY_W'($urandom_range(0, 255));
      else delay = DELAY_W'($urandom_range(0, 6));
      if ($urandom_range(0, 40) == 0) pulse_reset("rand_rst", $urandom_range(1, 3));
      step("rand", $urandom_range(1, 6));
    end
    sig_in = 1'b0;
    delay  = 8'd0;
    step("rand_tail", 270);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
